div_unit: RTL and testbench

//  Multicycle signed 32-bit divider serving MIPS DIV in the multicycle CPU datapath.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider width and divider FSM state encoding.
package cpu_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ZERO = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider for MIPS DIV.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_stop,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             stop_q;
  logic             zero_q;
  logic             busy_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Trial subtraction for one restoring step, plus operand magnitudes and result sign fix-up.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    rem_d     = rem_shift[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
    // Unsigned magnitudes: the most negative value maps onto itself, which is still correct.
    a_mag   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    quo_fix = sign_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
    rem_fix = sign_r_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  // Divider FSM and datapath; all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      stop_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      stop_q <= 1'b0;
      zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (b == '0) begin
              state_q <= ZERO;
            end else begin
              quo_q    <= a_mag;
              dvs_q    <= b_mag;
              rem_q    <= '0;
              cnt_q    <= '0;
              sign_q_q <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r_q <= a[WIDTH-1];
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          lo_q    <= quo_fix;
          hi_q    <= rem_fix;
          stop_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ZERO: begin
          // Zero divisor: flag only, leave hi/lo untouched.
          zero_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_stop = stop_q;
  assign div_zero = zero_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed cases plus randomized operands against a reference model.
module tb_div_unit;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_stop;
  logic        div_zero;
  logic        busy;

  div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .div_stop (div_stop),
    .div_zero (div_zero),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed division truncating toward zero, with the one overflow case pinned.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] r);
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = 32'($signed(x) / $signed(y));
      r = 32'($signed(x) % $signed(y));
    end
  endtask

  // Pops an expectation whenever the DUT pulses and compares result and latency.
  task automatic monitor();
    bit   prev_stop = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stop = 1'b0;
      end else begin
        if (prev_stop) check("busy_after_stop", 32'(busy), 32'h0);
        prev_stop = div_stop;
        if (div_stop || div_zero) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: stop=%0b zero=%0b with nothing outstanding (cycle %0d)",
                     div_stop, div_zero, cyc);
          end else begin
            e = sb.pop_front();
            check("pulse_stop", 32'(div_stop), 32'(!e.is_zero));
            check("pulse_zero", 32'(div_zero), 32'(e.is_zero));
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("latency", 32'(cyc - e.issue), e.is_zero ? 32'd1 : 32'd33);
          end
        end
      end
    end
  endtask

  // Drive one start pulse; operands are scrambled afterwards since only latched copies count.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit push,
                       input bit is_zero, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    @(negedge clock);
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      e.is_zero = is_zero;
      e.hi      = ehi;
      e.lo      = elo;
      e.issue   = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (sb.size() == 0 && !busy) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout: %0d results outstanding, busy=%0b (cycle %0d)", sb.size(), busy, cyc);
    sb.delete();
  endtask

  // Issue a division with explicit expected results and wait for it.
  task automatic run_exp(input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo);
    bit z;
    z = (bv == 32'h0);
    if (z) begin
      issue(av, bv, 1'b1, 1'b1, m_hi, m_lo);
    end else begin
      issue(av, bv, 1'b1, 1'b0, ehi, elo);
      m_hi = ehi;
      m_lo = elo;
    end
    wait_done();
  endtask

  task automatic run_model(input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] q;
    logic [31:0] r;
    if (bv == 32'h0) begin
      run_exp(av, bv, m_hi, m_lo);
    end else begin
      ref_div(av, bv, q, r);
      run_exp(av, bv, r, q);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(20));
      3:       return 32'(-$signed(32'($urandom_range(20))));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stop", 32'(div_stop), 32'h0);
    check("rst_zero", 32'(div_zero), 32'h0);

    // Sign combinations and overflow.
    run_exp(32'd7,          32'd2,          32'h0000_0001, 32'h0000_0003);
    run_exp(32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_exp(32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD);
    run_exp(32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'h0000_0003);
    run_exp(32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000);

    // Zero divisor after a preload: hi/lo must hold.
    run_exp(32'd7, 32'd2, 32'h0000_0001, 32'h0000_0003);
    run_exp(32'd5, 32'd0, 32'h0000_0001, 32'h0000_0003);
    check("zero_hold_hi", hi, 32'h0000_0001);
    check("zero_hold_lo", lo, 32'h0000_0003);

    // Start while busy is ignored; reset mid-operation aborts with no pulse.
    issue(32'd7, 32'd2, 1'b1, 1'b0, 32'h1, 32'h3);
    repeat (8) @(negedge clock);
    a     = 32'd100;
    b     = 32'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    repeat (30) @(negedge clock);
    check("abort_idle_hi", hi, 32'h0);
    run_exp(32'd100, 32'd7, 32'd2, 32'd14);

    // Randomized operands against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = pick();
      rb = ($urandom_range(31) == 0) ? 32'h0 : pick();
      run_model(ra, rb);
    end

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
